spi_master: RTL

//  SPI mode-0 master (CPOL=0, CPHA=0, MSB first), the initiator end of the link served by spi_slave.

---
 rtl/spi_master.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with TX/RX FIFOs.
// Optional SPI_MASTER_BURST_EN keeps cs low across back-to-back bytes.
module spi_master #(
    parameter int CLK_DIV    = 25,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] tx_data_i,
    input  logic       tx_wr_en_i,
    output logic       tx_full_o,
    output logic [7:0] rx_data_o,
    input  logic       rx_rd_en_i,
    output logic       rx_empty_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       cs_o,
    output logic       mosi_o,
    input  logic       miso_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        IDLE, LEAD, HIGH, TRAIL, GAP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          sclk_q, sclk_d;
    logic          cs_q, cs_d;
    logic          mosi_q, mosi_d;
    logic          tick;
    logic          tx_pop, rx_push;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW:0]   tx_wp_q, tx_rp_q;
    logic          tx_empty, tx_push;
    logic [7:0]    tx_head;

    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW:0]   rx_wp_q, rx_rp_q;
    logic          rx_full, rx_pop;
    logic [7:0]    rx_data_q;

    assign tx_empty  = (tx_wp_q == tx_rp_q);
    assign tx_full_o = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                       (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign tx_push   = tx_wr_en_i && !tx_full_o;
    assign tx_head   = tx_mem_q[tx_rp_q[AW-1:0]];

    assign rx_empty_o = (rx_wp_q == rx_rp_q);
    assign rx_full    = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                        (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign rx_pop     = rx_rd_en_i && !rx_empty_o;

`ifdef SPI_MASTER_BURST_EN
    logic [AW:0] rx_cnt;
    assign rx_cnt = rx_wp_q - rx_rp_q;
`endif

    assign tick      = (cnt_q == CW'(CLK_DIV - 1));
    assign busy_o    = (state_q != IDLE);
    assign sclk_o    = sclk_q;
    assign cs_o      = cs_q;
    assign mosi_o    = mosi_q;
    assign rx_data_o = rx_data_q;

    // FIFO storage arrays; contents are don't-care until pointers say valid
    always_ff @(posedge clk_i) begin
        if (tx_push)
            tx_mem_q[tx_wp_q[AW-1:0]] <= tx_data_i;
        if (rx_push)
            rx_mem_q[rx_wp_q[AW-1:0]] <= shift_q;
    end

    // FIFO pointers and registered RX read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            rx_data_q <= '0;
        end else begin
            if (tx_push)
                tx_wp_q <= tx_wp_q + (AW+1)'(1);
            if (tx_pop)
                tx_rp_q <= tx_rp_q + (AW+1)'(1);
            if (rx_push)
                rx_wp_q <= rx_wp_q + (AW+1)'(1);
            if (rx_pop) begin
                rx_rp_q   <= rx_rp_q + (AW+1)'(1);
                rx_data_q <= rx_mem_q[rx_rp_q[AW-1:0]];
            end
        end
    end

    // FSM, divider and bus output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
        end
    end

    // Next state: shift_q[7] is always the next bit to drive; miso enters at LSB
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        if (state_q != IDLE && !tick)
            cnt_d = cnt_q + CW'(1);
        unique case (state_q)
            IDLE: begin
                if (!tx_empty && !rx_full) begin
                    tx_pop    = 1'b1;
                    shift_d   = tx_head;
                    mosi_d    = tx_head[7];
                    cs_d      = 1'b0;
                    bit_cnt_d = 3'd7;
                    state_d   = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[6:0], miso_i};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q != 3'd0) begin
                        mosi_d    = shift_q[7];
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        state_d   = LEAD;
                    end else begin
                        rx_push = 1'b1;
                        state_d = TRAIL;
`ifdef SPI_MASTER_BURST_EN
                        if (!tx_empty &&
                            rx_cnt < (AW+1)'(FIFO_DEPTH - 1)) begin
                            tx_pop    = 1'b1;
                            shift_d   = tx_head;
                            mosi_d    = tx_head[7];
                            bit_cnt_d = 3'd7;
                            state_d   = LEAD;
                        end
`endif
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
